// File: rtl/alu_op_decoder.sv
// RV32I decode stage: one registered output slot producing ALU select, immediate and operand controls.
// Optional macro ALU_DEC_ILLEGAL_EN adds a registered 'illegal' flag output.
module alu_op_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] imm,
  output logic            op1_pc,
  output logic            op2_imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic [XLEN-1:0] out_pc
`ifdef ALU_DEC_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] imm;
    logic            op1_pc;
    logic            op2_imm;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic            load;
  dec_t            dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // shift-immediates carry only the shamt, not the funct7 bits
  assign imm_sh = {27'b0, instr[24:20]};

  // funct3 to ALU code for the non-alternate OP/OP-IMM group
  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec         = '0;
    dec.alu_sel = ALU_NOP;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_BASE)                          dec.alu_sel = f3_alu(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)  dec.alu_sel = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)  dec.alu_sel = ALU_SRA;
        else                                            dec.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.op2_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_sel   = f3_alu(funct3);
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          if (funct7 != F7_BASE) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          if (funct7 == F7_ALT)       dec.alu_sel = ALU_SRA;
          else if (funct7 != F7_BASE) dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.op2_imm   = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec.alu_sel   = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.op1_pc    = 1'b1;
        dec.op2_imm   = 1'b1;
        dec.imm       = (opcode == OPC_JAL) ? imm_j : imm_u;
      end
      OPC_LOAD: begin
        dec.alu_sel   = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.op2_imm   = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.alu_sel = ALU_ADD;
        dec.op2_imm = 1'b1;
        dec.imm     = imm_s;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (funct3[2:1])
          2'b00:   dec.alu_sel = ALU_SUB;
          2'b10:   dec.alu_sel = ALU_SLT;
          2'b11:   dec.alu_sel = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JALR: begin
        dec.alu_sel   = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.op2_imm   = 1'b1;
        dec.imm       = imm_i;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
    // illegal words leave as bubbles so execute never acts on them
    if (dec.illegal) begin
      dec.alu_sel   = ALU_NOP;
      dec.imm       = '0;
      dec.op1_pc    = 1'b0;
      dec.op2_imm   = 1'b0;
      dec.reg_write = 1'b0;
    end
    if (instr[11:7] == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_sel   <= ALU_NOP;
      imm       <= '0;
      op1_pc    <= 1'b0;
      op2_imm   <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      reg_write <= 1'b0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      alu_sel   <= dec.alu_sel;
      imm       <= dec.imm;
      op1_pc    <= dec.op1_pc;
      op2_imm   <= dec.op2_imm;
      rs1       <= instr[19:15];
      rs2       <= instr[24:20];
      rd        <= instr[11:7];
      reg_write <= dec.reg_write;
      out_pc    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_DEC_ILLEGAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 illegal <= 1'b0;
    else if (!flush && load) illegal <= dec.illegal;
  end
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed vector bench for alu_op_decoder: streamed decode table plus stall, flush, drain and reset sequences.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, in_pc, imm, out_pc;
  logic [3:0]  alu_sel;
  logic        op1_pc, op2_imm, reg_write;
  logic [4:0]  rs1, rs2, rd;
`ifdef ALU_DEC_ILLEGAL_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_decoder #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .imm(imm), .op1_pc(op1_pc), .op2_imm(op2_imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .out_pc(out_pc)
`ifdef ALU_DEC_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        chk_imm;
    logic        op1_pc;
    logic        op2_imm;
    logic        rw;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [3:0] a, input logic [31:0] im,
                              input logic ci, input logic p1, input logic p2, input logic w,
                              input logic il, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2);
    vec_t v;
    v.instr = i; v.alu = a; v.imm = im; v.chk_imm = ci; v.op1_pc = p1; v.op2_imm = p2;
    v.rw = w; v.ill = il; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    return v;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    instr    = i;
    in_pc    = pc;
  endtask

  initial begin
    //             instr         alu    imm           ci p1 p2 w  il rd  rs1 rs2
    vecs[0]  = mk(32'h40B50533, 4'd1,  32'h0,        0, 0, 0, 1, 0, 10, 10, 11); // sub a0,a0,a1
    vecs[1]  = mk(32'h4041D193, 4'd4,  32'h4,        1, 0, 1, 1, 0, 3,  3,  4);  // srai x3,x3,4
    vecs[2]  = mk(32'hFFF00113, 4'd0,  32'hFFFFFFFF, 1, 0, 1, 1, 0, 2,  0,  31); // addi x2,x0,-1
    vecs[3]  = mk(32'h123452B7, 4'd10, 32'h12345000, 1, 0, 1, 1, 0, 5,  8,  3);  // lui
    vecs[4]  = mk(32'h0000007F, 4'd10, 32'h0,        1, 0, 0, 0, 1, 0,  0,  0);  // bad opcode
    vecs[5]  = mk(32'hFFFFF097, 4'd0,  32'hFFFFF000, 1, 1, 1, 1, 0, 1,  31, 31); // auipc
    vecs[6]  = mk(32'hFE512E23, 4'd0,  32'hFFFFFFFC, 1, 0, 1, 0, 0, 28, 2,  5);  // sw x5,-4(x2)
    vecs[7]  = mk(32'hFE208CE3, 4'd1,  32'hFFFFFFF8, 1, 0, 0, 0, 0, 25, 1,  2);  // beq -8
    vecs[8]  = mk(32'h001000EF, 4'd0,  32'h00000800, 1, 1, 1, 1, 0, 1,  0,  1);  // jal +2048
    vecs[9]  = mk(32'h00208033, 4'd0,  32'h0,        0, 0, 0, 0, 0, 0,  1,  2);  // add x0 -> no write
    vecs[10] = mk(32'h00002063, 4'd10, 32'h0,        1, 0, 0, 0, 1, 0,  0,  0);  // branch f3=010
    vecs[11] = mk(32'h0041E063, 4'd6,  32'h0,        1, 0, 0, 0, 0, 0,  3,  4);  // bltu
    vecs[12] = mk(32'h02208033, 4'd10, 32'h0,        1, 0, 0, 0, 1, 0,  1,  2);  // OP funct7=1
    vecs[13] = mk(32'h40109093, 4'd10, 32'h0,        1, 0, 0, 0, 1, 1,  1,  1);  // slli bad funct7
    vecs[14] = mk(32'h000280E7, 4'd0,  32'h0,        1, 0, 1, 1, 0, 1,  5,  0);  // jalr x1,0(x5)
    vecs[15] = mk(32'h00000073, 4'd10, 32'h0,        1, 0, 0, 0, 0, 0,  0,  0);  // ecall
    vecs[16] = mk(32'hFFF13093, 4'd6,  32'hFFFFFFFF, 1, 0, 1, 1, 0, 1,  2,  31); // sltiu
    vecs[17] = mk(32'h403150B3, 4'd4,  32'h0,        0, 0, 0, 1, 0, 1,  2,  3);  // sra

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.alu_sel",   32'(alu_sel),   32'd10);
    chk("rst.imm",       imm,            32'd0);
    chk("rst.rd",        32'(rd),        32'd0);
    chk("rst.reg_write", 32'(reg_write), 32'd0);
    chk("rst.out_pc",    out_pc,         32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
`ifdef ALU_DEC_ILLEGAL_EN
    chk("rst.illegal",   32'(illegal),   32'd0);
`endif
    rst = 1'b0;

    // back-to-back stream: one word per cycle, checked one cycle after issue
    @(negedge clk);
    drive(vecs[0].instr, 32'h1000);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d.alu_sel", i),   32'(alu_sel),   32'(vecs[i].alu));
      if (vecs[i].chk_imm) chk($sformatf("v%0d.imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d.op1_pc", i),    32'(op1_pc),    32'(vecs[i].op1_pc));
      chk($sformatf("v%0d.op2_imm", i),   32'(op2_imm),   32'(vecs[i].op2_imm));
      chk($sformatf("v%0d.reg_write", i), 32'(reg_write), 32'(vecs[i].rw));
      chk($sformatf("v%0d.rd", i),        32'(rd),        32'(vecs[i].rd));
      chk($sformatf("v%0d.rs1", i),       32'(rs1),       32'(vecs[i].rs1));
      chk($sformatf("v%0d.rs2", i),       32'(rs2),       32'(vecs[i].rs2));
      chk($sformatf("v%0d.out_pc", i),    out_pc,         32'h1000 + 32'(4 * i));
`ifdef ALU_DEC_ILLEGAL_EN
      chk($sformatf("v%0d.illegal", i),   32'(illegal),   32'(vecs[i].ill));
`endif
      if (i + 1 < NV) drive(vecs[i + 1].instr, 32'h1000 + 32'(4 * (i + 1)));
      else            in_valid = 1'b0;
    end

    // drain with nothing new: valid drops, fields hold
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.alu_sel",   32'(alu_sel),   32'd4);
    chk("drain.rd",        32'(rd),        32'd1);

    // stall: lui held for 3 cycles while an addi waits
    drive(32'h123452B7, 32'h2000);
    @(negedge clk);
    chk("stall.load_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    drive(32'hFFF00113, 32'h2004);
    #1;
    chk("stall.in_ready0", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d.alu_sel", c),   32'(alu_sel),   32'd10);
      chk($sformatf("stall%0d.imm", c),       imm,            32'h12345000);
      chk($sformatf("stall%0d.out_pc", c),    out_pc,         32'h2000);
      chk($sformatf("stall%0d.in_ready", c),  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.in_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("stall.next_valid", 32'(out_valid), 32'd1);
    chk("stall.next_alu",   32'(alu_sel),   32'd0);
    chk("stall.next_imm",   imm,            32'hFFFFFFFF);
    chk("stall.next_pc",    out_pc,         32'h2004);

    // flush beats a same-cycle load; held fields do not change
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(32'h40B50533, 32'h3000);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.alu_sel",   32'(alu_sel),   32'd0);
    chk("flush.out_pc",    out_pc,         32'h2004);
    @(negedge clk);
    chk("flush.stays_idle", 32'(out_valid), 32'd0);

    // asynchronous reset mid-stream, sampled between clock edges
    drive(32'h40B50533, 32'h4000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.out_valid_pre", 32'(out_valid), 32'd1);
    chk("mid.alu_pre",       32'(alu_sel),   32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.alu_sel",   32'(alu_sel),   32'd10);
    chk("mid.rd",        32'(rd),        32'd0);
    chk("mid.out_pc",    out_pc,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Registered RV32I decode stage that produces the 4-bit ALU select code, the immediate and the operand-select controls consumed by the ALU.
- Sits between the fetch buffer and the execute stage.
- Holds a single-entry output register with a valid/ready handshake on both sides, so fetch and execute can stall independently.
- Supports a synchronous flush for branch redirects.

Parameters:
XLEN, 32, instruction width, immediate width and output width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard the held and incoming instruction
in_valid  input  1  instr/in_pc valid
in_ready  output  1  stage can accept this cycle
instr  input  XLEN  raw instruction word
in_pc  input  XLEN  PC of instr
out_valid  output  1  decoded fields valid
out_ready  input  1  execute accepts this cycle
alu_sel  output  4  ALU operation code
imm  output  XLEN  sign-extended immediate
op1_pc  output  1  ALU operand 1 = PC instead of rs1
op2_imm  output  1  ALU operand 2 = imm instead of rs2
rs1  output  5  source register 1 index
rs2  output  5  source register 2 index
rd  output  5  destination register index
reg_write  output  1  rd written; forced 0 when rd==0
out_pc  output  XLEN  registered in_pc

Behaviour:
- Reset is asynchronous and active-high.
  - out_valid=0.
  - alu_sel=10 (NOP).
  - All other outputs 0.
- alu_sel encoding is fixed: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, SLT=5, SLTU=6, XOR=7, OR=8, AND=9, NOP=10. Codes 11-15 are never produced.
- in_ready = !out_valid || out_ready (combinational).
- Load condition: in_valid && in_ready && !flush.
  - Decode instr and register all outputs.
  - out_valid<=1 next cycle.
  - Latency is exactly 1 cycle.
- Drain with no load: if out_valid && out_ready and nothing is loaded, out_valid<=0.
- Stall: if out_valid && !out_ready, all outputs hold stable.
- Flush:
  - out_valid<=0 next cycle.
  - A same-cycle input is dropped; in_ready may still be 1.
  - Flush has priority over load.
- Simultaneous drain and load: the new word replaces the held one. Full throughput is one instruction per cycle.
- Output fields while out_valid=0 are don't-care, but must not change unless a load occurs.
- Immediate formats, all sign-extended from bit 31: I, S, B (bit0=0), U (low 12 bits=0), J (bit0=0).
- Decode by opcode[6:0]:
  - 0110011 OP: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 with funct3 000 selects SUB; with funct3 101 selects SRA. Any other funct7 (not 0000000) is illegal. op2_imm=0.
  - 0010011 OP-IMM: same as OP but without SUB; imm uses I format; op2_imm=1. SLLI requires funct7=0000000. SRLI/SRAI are distinguished by funct7 (0000000/0100000); any other funct7 is illegal.
  - 0110111 LUI: NOP, U-imm, op2_imm=1.
  - 0010111 AUIPC: ADD, U-imm, op1_pc=1, op2_imm=1.
  - 0000011 LOAD: ADD, I-imm, op2_imm=1.
  - 0100011 STORE: ADD, S-imm, op2_imm=1, reg_write=0.
  - 1100011 BRANCH: reg_write=0, op2_imm=0, imm=B.
    - beq/bne -> SUB.
    - blt/bge -> SLT.
    - bltu/bgeu -> SLTU.
    - funct3 010/011 is illegal.
  - 1101111 JAL: ADD, J-imm, op1_pc=1, op2_imm=1.
  - 1100111 JALR (funct3=000): ADD, I-imm, op2_imm=1.
  - 0001111 FENCE and 1110011 SYSTEM: NOP, reg_write=0.
  - Anything else is illegal.
- Illegal instruction: alu_sel=NOP, reg_write=0, op1_pc=0, op2_imm=0, imm=0.
- rs1/rs2/rd are always raw instr[19:15]/[24:20]/[11:7], whatever the format.

Optional Feature:
Macro ALU_DEC_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit, reset 0). It is registered with the other fields, is 1 for each decoded word that hits an illegal case, and holds under stall.
- Undefined: the port is absent. Illegal words are still forced to the NOP/no-write form above, so execute treats them as bubbles.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 -> out_valid=0 and alu_sel=10 immediately, without waiting for a clock edge.
- instr=0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle:
  - out_valid=1, alu_sel=1, rd=10, rs1=10, rs2=11, op2_imm=0, reg_write=1.
- instr=0x4041D193 (srai x3,x3,4) -> alu_sel=4, imm=4, op2_imm=1.
- instr=0xFFF00113 (addi x2,x0,-1) -> alu_sel=0, imm=0xFFFFFFFF.
- Back-to-back with stall: load 0x123452B7 (lui) then hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable (alu_sel=10, imm=0x12345000). On out_ready=1 the next word loads in the same cycle.
- flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle; the incoming word is dropped.
- instr=0x0000007F (illegal) -> alu_sel=10, reg_write=0, plus illegal=1 when ALU_DEC_ILLEGAL_EN is defined.
